alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width.
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 SHALL have ports reqN_ready  output  1  requester N operation accepted this cycle.
REQ-007 SHALL have ports reqN_a, reqN_b  input  WIDTH  operands for requester N.
REQ-008 SHALL have ports reqN_op  input  OPW  opcode for requester N.
REQ-009 SHALL have ports alu_num1, alu_num2  output  WIDTH  operands to the shared ALU.
REQ-010 SHALL have port alu_op  output  OPW  opcode to the shared ALU.
REQ-011 SHALL have ports alu_out  input  WIDTH and alu_z  input  1  ALU result and zero flag.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have ports rsp_data  output  WIDTH, rsp_z  output  1, rsp_id  output  1, rsp_err  output  1  result, zero flag, requester index, illegal-opcode flag.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-016 In IDLE, SHALL grant at most one requester per cycle; reqN_ready asserted combinationally only in IDLE for the granted N with reqN_valid=1; both readys never high together.
REQ-017 Arbitration SHALL be round-robin: one valid -> grant it; both valid -> grant the requester not granted last; after reset req0 has priority.
REQ-018 On grant (cycle T), SHALL latch a, b, op, id into internal registers and move to EXEC at T+1.
REQ-019 alu_num1/alu_num2/alu_op SHALL be driven from the latched registers at all times (no combinational path from reqN_* to alu_*).
REQ-020 Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS-B, 1100 NOR; any other value is illegal.
REQ-021 In EXEC (one cycle), SHALL capture alu_out into rsp_data and alu_z into rsp_z at end of cycle, rsp_err=0, then enter RESP.
REQ-022 Illegal opcode: SHALL still accept, pass through EXEC, and capture rsp_data=0, rsp_z=0, rsp_err=1 (ALU output ignored).
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_z/rsp_id/rsp_err SHALL be stable until the cycle rsp_ready=1; then return to IDLE next cycle.
REQ-024 Latency: grant at T -> rsp_valid=1 at T+2 earliest; minimum 3 cycles per transaction; no request accepted while in EXEC or RESP.
REQ-025 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-026 Round-robin pointer SHALL update only on grant, to the granted index.
REQ-027 A requester dropping valid before grant SHALL lose no state and cause no side effect.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, rsp_valid=0, rsp_data=0, rsp_z=0, rsp_id=0, rsp_err=0, latched a/b/op=0, pointer favoring req0.
REQ-029 Reset during EXEC or RESP SHALL abort the transaction; no response for it is ever produced.
REQ-030 reqN_ready SHALL be 0 in any cycle rst=1.

Verification
REQ-031 req0 a=5,b=3,op=0010, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2 with data=8, z=0, id=0, err=0.
REQ-032 Both valid every cycle, req0 op=0110 a=b=7, req1 op=0000 a=F0,b=0F -> grants alternate 0,1,0,1; responses data=0 z=1 id=0, then data=0 z=1 id=1.
REQ-033 req1 op=0011 -> accepted, response data=0, z=0, err=1, id=1.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both reqN_ready=0, response delivered on first rsp_ready=1.
REQ-035 rst asserted in EXEC -> next cycle IDLE, rsp_valid never rises for that transaction, next grant goes to req0 if both valid.
REQ-036 op=1100 a=b=0 -> data=all ones (WIDTH bits), z=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU: grant, execute, hold response until it is taken.
// Latency: grant at T, response valid at T+2; each transaction takes at least 3 cycles.
// Backpressure: the response is held stable while rsp_ready is low, and no new grant is made until it is taken.
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_id,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             z_q, z_d;
    logic             rid_q, rid_d;
    logic             err_q, err_d;
    logic             grant0, grant1;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        logic ok;
        ok = 1'b0;
        if (op == OPW'(4'b0000) || op == OPW'(4'b0001) || op == OPW'(4'b0010) ||
            op == OPW'(4'b0110) || op == OPW'(4'b0111) || op == OPW'(4'b1100))
            ok = 1'b1;
        return ok;
    endfunction

    // last_q holds the index granted most recently; the other requester wins a tie.
    assign grant0 = req0_valid && (!req1_valid || last_q);
    assign grant1 = req1_valid && !grant0;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        id_d       = id_q;
        last_d     = last_q;
        data_d     = data_q;
        z_d        = z_q;
        rid_d      = rid_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && (grant0 || grant1)) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                    a_d        = grant1 ? req1_a  : req0_a;
                    b_d        = grant1 ? req1_b  : req0_b;
                    op_d       = grant1 ? req1_op : req0_op;
                    id_d       = grant1;
                    last_d     = grant1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (op_legal(op_q)) begin
                    data_d = alu_out;
                    z_d    = alu_z;
                    err_d  = 1'b0;
                end else begin
                    data_d = '0;
                    z_d    = 1'b0;
                    err_d  = 1'b1;
                end
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
            z_q     <= 1'b0;
            rid_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            data_q  <= data_d;
            z_q     <= z_d;
            rid_q   <= rid_d;
            err_q   <= err_d;
        end
    end

    assign alu_num1  = a_q;
    assign alu_num2  = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_z     = z_q;
    assign rsp_id    = rid_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus random traffic against a transaction-level model and scoreboard.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [63:0] alu_num1, alu_num2, alu_out;
    logic [3:0]  alu_op;
    logic        alu_z;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_z, rsp_id, rsp_err;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(64), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    // External ALU; illegal opcodes produce a nonzero junk value the arbiter must discard.
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_num1 & alu_num2;
            4'b0001: alu_out = alu_num1 | alu_num2;
            4'b0010: alu_out = alu_num1 + alu_num2;
            4'b0110: alu_out = alu_num1 - alu_num2;
            4'b0111: alu_out = alu_num2;
            4'b1100: alu_out = ~(alu_num1 | alu_num2);
            default: alu_out = {alu_num1[31:0], 32'hDEAD_BEEF};
        endcase
        alu_z = (alu_out == 64'd0);
    end

    typedef struct {
        logic [63:0] data;
        logic        z;
        logic        id;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          stage  = 0;
    int          last   = 1;
    logic [63:0] cur_a, cur_b;
    logic [3:0]  cur_op;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic rsp_t ref_rsp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input int id);
        rsp_t r;
        r.id  = (id == 1);
        r.err = 1'b0;
        case (op)
            4'd0:    r.data = a & b;
            4'd1:    r.data = a | b;
            4'd2:    r.data = a + b;
            4'd6:    r.data = a - b;
            4'd7:    r.data = b;
            4'd12:   r.data = ~(a | b);
            default: begin r.data = 64'd0; r.err = 1'b1; end
        endcase
        r.z = !r.err && (r.data == 64'd0);
        return r;
    endfunction

    task automatic set_req(input logic v0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] o0,
                           input logic v1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] o1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    endtask

    // Inputs have just been driven at a negedge; check combinational grant and advance the model one cycle.
    task automatic step();
        int g;
        #1;
        chk("rsp_valid_phase", rsp_valid, stage == 2);
        if (rst) begin
            chk("ready_in_reset", {req1_ready, req0_ready}, 2'b00);
            stage = 0;
            last  = 1;
            exp_q.delete();
        end else if (stage == 0) begin
            g = -1;
            if (req0_valid && req1_valid) g = (last == 0) ? 1 : 0;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
            chk("grant", {req1_ready, req0_ready}, (g < 0) ? 0 : ((g == 0) ? 1 : 2));
            if (g >= 0) begin
                cur_a  = (g == 0) ? req0_a  : req1_a;
                cur_b  = (g == 0) ? req0_b  : req1_b;
                cur_op = (g == 0) ? req0_op : req1_op;
                exp_q.push_back(ref_rsp(cur_op, cur_a, cur_b, g));
                last  = g;
                stage = 1;
            end
        end else if (stage == 1) begin
            chk("ready_busy_exec", {req1_ready, req0_ready}, 2'b00);
            chk("alu_num1", alu_num1, cur_a);
            chk("alu_num2", alu_num2, cur_b);
            chk("alu_op", alu_op, cur_op);
            stage = 2;
        end else begin
            chk("ready_busy_resp", {req1_ready, req0_ready}, 2'b00);
            if (rsp_ready) stage = 0;
        end
        @(negedge clk);
    endtask

    // Monitor: every cycle a response is presented it must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    chk("rsp_z", rsp_z, exp_q[0].z);
                    chk("rsp_id", rsp_id, exp_q[0].id);
                    chk("rsp_err", rsp_err, exp_q[0].err);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] ops[8];
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        step();
        rst = 1'b0;
        #1;
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_flags", {rsp_z, rsp_id, rsp_err}, 3'b000);
        chk("reset_alu_a", alu_num1, 64'd0);
        chk("reset_alu_op", alu_op, 4'd0);
        @(negedge clk);

        // 5 + 3 on req0
        set_req(1, 64'd5, 64'd3, 4'b0010, 0, 0, 0, 0);
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Alternating grants with both requesters always valid, after reset restores req0 priority
        rst = 1'b1; step(); rst = 1'b0;
        set_req(1, 64'd7, 64'd7, 4'b0110, 1, 64'hF0, 64'h0F, 4'b0000);
        repeat (12) step();

        // Illegal opcode from req1
        set_req(0, 0, 0, 0, 1, 64'h1234, 64'h5678, 4'b0011);
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Consumer stalls in RESP
        set_req(1, 64'hAA, 64'h55, 4'b0001, 1, 64'd9, 64'd4, 4'b0110);
        rsp_ready = 1'b0;
        repeat (7) step();
        rsp_ready = 1'b1;
        repeat (2) step();

        // Reset during EXEC aborts the transaction; req0 wins the next tie
        set_req(1, 64'd1, 64'd2, 4'b0010, 1, 64'd3, 64'd4, 4'b0010);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (4) step();

        // NOR of zeros gives all ones
        set_req(1, 64'd0, 64'd0, 4'b1100, 0, 0, 0, 0);
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        for (int i = 0; i < 600; i++) begin
            set_req($urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom}, ops[$urandom_range(0, 7)],
                    $urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom}, ops[$urandom_range(0, 7)]);
            if ($urandom_range(0, 3) == 0) req0_b = req0_a;
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();
        chk("drain_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
